// File: rtl/udma_tx_word_serializer.sv
// udma_tx_word_serializer: splits FIFO words into little-endian bytes, remaps sof/eof to bytes, counts frame bytes
module udma_tx_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [7:0]            data_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o,
  output logic                  busy_o
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_sof, r_eof, r_cnt_clr;
  logic [0:0]            r_full;
  logic [2:0]            r_nbytes;
  logic [1:0]            r_idx;
  logic [CNT_WIDTH-1:0]  r_cnt, cnt_base;
  logic                  last, hs_in, hs_out;
  assign last        = {1'b0, r_idx} == r_nbytes - 3'd1;
  assign valid_o     = r_full == SHIFT;
  assign data_o      = valid_o ? r_word[{r_idx, 3'b000} +: 8] : 8'h00;
  assign sof_o       = valid_o & r_sof & (r_idx == 2'd0);
  assign eof_o       = valid_o & r_eof & last;
  assign hs_out      = valid_o & ready_i & ~clr_i;
  // ready_i feeds ready_o combinationally so the next word loads as the last byte leaves
  assign ready_o     = ~clr_i & (~valid_o | (ready_i & last));
  assign hs_in       = valid_i & ready_o;
  assign busy_o      = valid_o;
  assign frame_cnt_o = r_cnt;
  // a count that ended a frame is shown for one cycle, then treated as zero
  assign cnt_base    = r_cnt_clr ? '0 : r_cnt;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_word    <= '0;
      r_sof     <= 1'b0;
      r_eof     <= 1'b0;
      r_nbytes  <= 3'd1;
      r_idx     <= 2'd0;
      r_full    <= EMPTY;
      r_cnt     <= '0;
      r_cnt_clr <= 1'b0;
    end else if (clr_i) begin
      r_full    <= EMPTY;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_cnt_clr <= 1'b0;
    end else begin
      if (hs_in) begin
        r_word   <= data_i;
        r_sof    <= sof_i;
        r_eof    <= eof_i;
        r_nbytes <= cfg_datasize_i == 2'd0 ? 3'd1 : cfg_datasize_i == 2'd1 ? 3'd2 : 3'd4;
        r_idx    <= 2'd0;
        r_full   <= SHIFT;
      end else if (hs_out) begin
        if (last) r_full <= EMPTY;
        else r_idx <= r_idx + 2'd1;
      end
      r_cnt     <= hs_out ? (sof_o ? CNT_ONE : (&cnt_base ? cnt_base : cnt_base + CNT_ONE)) : cnt_base;
      r_cnt_clr <= hs_out & eof_o;
    end
  end
endmodule

// File: tb/tb_udma_tx_word_serializer.sv
// tb_udma_tx_word_serializer: directed scenarios plus randomized stream against a byte-list model
module tb_udma_tx_word_serializer;
  logic        clk_i = 1'b0, rstn_i = 1'b0, clr_i = 1'b0;
  logic [1:0]  cfg_datasize_i = 2'd0;
  logic [31:0] data_i = '0;
  logic        sof_i = 1'b0, eof_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic        ready_o, sof_o, eof_o, valid_o, busy_o;
  logic [7:0]  data_o;
  logic [15:0] frame_cnt_o;
  int checks = 0, errors = 0;
  bit gaps = 0;
  typedef struct {logic [31:0] d; logic s; logic e; logic [1:0] ds;} word_t;
  typedef struct {logic [7:0] d; logic s; logic e;} byte_t;
  word_t in_q[$];
  byte_t out_q[$];
  logic rdy_q[$], vld_q[$], rdyo_q[$], rdi_q[$], hs_q[$];
  logic [7:0] dat_q[$];
  logic [15:0] cnt_q[$];

  udma_tx_word_serializer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .clr_i(clr_i), .cfg_datasize_i(cfg_datasize_i),
    .data_i(data_i), .sof_i(sof_i), .eof_i(eof_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .sof_o(sof_o), .eof_o(eof_o), .valid_o(valid_o), .ready_i(ready_i),
    .frame_cnt_o(frame_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // drives in_q words, records per-cycle outputs (sampled mid-cycle) until idle plus two cycles
  task automatic stream(input int budget);
    int n = 0;
    int tail = 0;
    bit acc;
    out_q.delete(); vld_q.delete(); rdyo_q.delete(); rdi_q.delete(); hs_q.delete(); dat_q.delete(); cnt_q.delete();
    while (tail < 3 && n < budget) begin
      valid_i = in_q.size() > 0 && (!gaps || $urandom_range(3) != 0);
      if (in_q.size() > 0) begin
        data_i = in_q[0].d; sof_i = in_q[0].s; eof_i = in_q[0].e; cfg_datasize_i = in_q[0].ds;
      end
      if (rdy_q.size() > 0) ready_i = rdy_q.pop_front();
      else ready_i = 1'b1;
      #4;
      vld_q.push_back(valid_o); dat_q.push_back(data_o); rdyo_q.push_back(ready_o);
      rdi_q.push_back(ready_i); cnt_q.push_back(frame_cnt_o); hs_q.push_back(valid_o && ready_i);
      if (valid_o && ready_i) out_q.push_back('{data_o, sof_o, eof_o});
      acc = valid_i && ready_o;
      @(posedge clk_i); #1;
      if (acc) void'(in_q.pop_front());
      if (in_q.size() == 0 && !busy_o) tail++;
      n++;
    end
    valid_i = 1'b0; ready_i = 1'b1; rdy_q.delete();
    checks++;
    if (n >= budget) begin errors++; $display("FAIL stream_timeout cycles=%0d budget=%0d", n, budget); end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || sof_o !== 1'b0 || eof_o !== 1'b0 ||
        frame_cnt_o !== 16'd0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got v=%b d=%h s=%b e=%b cnt=%0d busy=%b rdy=%b want 0 00 0 0 0 0 1",
               valid_o, data_o, sof_o, eof_o, frame_cnt_o, busy_o, ready_o);
    end
    @(posedge clk_i); #1 rstn_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_single_word();
    logic [7:0] eb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [15:0] ec[7] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    in_q.push_back('{32'h44332211, 1'b1, 1'b1, 2'd2});
    stream(50);
    checks++;
    if (out_q.size() != 4) begin errors++; $display("FAIL single_count got %0d want 4", out_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_q[i].d !== eb[i] || out_q[i].s !== (i == 0) || out_q[i].e !== (i == 3)) begin
        errors++;
        $display("FAIL single_byte%0d got %h s=%b e=%b want %h s=%b e=%b", i, out_q[i].d, out_q[i].s, out_q[i].e, eb[i], i == 0, i == 3);
      end
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= cnt_q.size() || cnt_q[i] !== ec[i]) begin
        errors++;
        $display("FAIL single_cnt cycle%0d got %0d want %0d", i, i < cnt_q.size() ? cnt_q[i] : 16'hffff, ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] eb[8] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
    in_q.push_back('{32'hA1B2C3D4, 1'b1, 1'b0, 2'd2});
    in_q.push_back('{32'h11223344, 1'b0, 1'b1, 2'd2});
    stream(50);
    checks++;
    if (out_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", out_q.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_q[i].d !== eb[i] || out_q[i].s !== (i == 0) || out_q[i].e !== (i == 7)) begin
        errors++;
        $display("FAIL b2b_byte%0d got %h s=%b e=%b want %h s=%b e=%b", i, out_q[i].d, out_q[i].s, out_q[i].e, eb[i], i == 0, i == 7);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (i >= vld_q.size() || vld_q[i] !== 1'b1 || rdyo_q[i] !== (i == 4 || i == 8)) begin
        errors++;
        $display("FAIL b2b_cycle%0d got valid=%b ready_o=%b want valid=1 ready_o=%b",
                 i, i < vld_q.size() ? vld_q[i] : 1'bx, i < rdyo_q.size() ? rdyo_q[i] : 1'bx, i == 4 || i == 8);
      end
    end
  endtask

  task automatic test_mixed_size();
    logic [7:0] eb[3] = '{8'hAA, 8'hBB, 8'hCC};
    in_q.push_back('{32'h000000AA, 1'b1, 1'b0, 2'd0});
    in_q.push_back('{32'h0000CCBB, 1'b0, 1'b1, 2'd1});
    stream(50);
    checks++;
    if (out_q.size() != 3) begin errors++; $display("FAIL mixed_count got %0d want 3", out_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_q[i].d !== eb[i] || out_q[i].s !== (i == 0) || out_q[i].e !== (i == 2)) begin
        errors++;
        $display("FAIL mixed_byte%0d got %h s=%b e=%b want %h s=%b e=%b", i, out_q[i].d, out_q[i].s, out_q[i].e, eb[i], i == 0, i == 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] eb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    in_q.push_back('{32'h44332211, 1'b1, 1'b1, 2'd2});
    stream(50);
    for (int i = 2; i <= 4; i++) begin
      checks++;
      if (vld_q[i] !== 1'b1 || dat_q[i] !== 8'h22 || rdyo_q[i] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle%0d got valid=%b data=%h ready_o=%b want 1 22 0", i, vld_q[i], dat_q[i], rdyo_q[i]);
      end
    end
    checks++;
    if (out_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", out_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_q[i].d !== eb[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, out_q[i].d, eb[i]); end
    end
  endtask

  task automatic test_clear();
    valid_i = 1'b1; data_i = 32'h44332211; sof_i = 1'b1; eof_i = 1'b0; cfg_datasize_i = 2'd2; ready_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (data_o !== 8'h22 || valid_o !== 1'b1) begin errors++; $display("FAIL clr_pre got valid=%b data=%h want 1 22", valid_o, data_o); end
    clr_i = 1'b1; valid_i = 1'b1; data_i = 32'hDEADBEEF; sof_i = 1'b1; eof_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL clr_ready got %b want 0", ready_o); end
    @(posedge clk_i); #1 clr_i = 1'b0; valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0 || frame_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL clr_after got valid=%b busy=%b cnt=%0d want 0 0 0", valid_o, busy_o, frame_cnt_o);
    end
    in_q.push_back('{32'h88776655, 1'b1, 1'b1, 2'd1});
    stream(50);
    checks++;
    if (out_q.size() != 2 || out_q[0].d !== 8'h55 || out_q[0].s !== 1'b1 || out_q[1].d !== 8'h66 || out_q[1].e !== 1'b1) begin
      errors++;
      $display("FAIL clr_restart got n=%0d first=%h want n=2 first=55 second=66", out_q.size(), out_q.size() > 0 ? out_q[0].d : 8'hxx);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] ec[4] = '{16'd0, 16'd0, 16'd1, 16'd0};
    valid_i = 1'b1; data_i = 32'h44332211; sof_i = 1'b1; eof_i = 1'b0; cfg_datasize_i = 2'd2; ready_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (valid_o !== 1'b1 || frame_cnt_o !== 16'd1) begin errors++; $display("FAIL arst_pre got valid=%b cnt=%0d want 1 1", valid_o, frame_cnt_o); end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00 || sof_o !== 1'b0 || eof_o !== 1'b0 ||
        frame_cnt_o !== 16'd0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL arst_values got v=%b d=%h s=%b e=%b cnt=%0d busy=%b rdy=%b want 0 00 0 0 0 0 1",
               valid_o, data_o, sof_o, eof_o, frame_cnt_o, busy_o, ready_o);
    end
    @(posedge clk_i); #1 rstn_i = 1'b1;
    in_q.push_back('{32'h0000005A, 1'b1, 1'b1, 2'd0});
    stream(50);
    checks++;
    if (out_q.size() != 1 || out_q[0].d !== 8'h5A || out_q[0].s !== 1'b1 || out_q[0].e !== 1'b1) begin
      errors++;
      $display("FAIL arst_single got n=%0d byte=%h s=%b e=%b want 1 5a 1 1", out_q.size(),
               out_q.size() > 0 ? out_q[0].d : 8'hxx, out_q.size() > 0 ? out_q[0].s : 1'bx, out_q.size() > 0 ? out_q[0].e : 1'bx);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= cnt_q.size() || cnt_q[i] !== ec[i]) begin
        errors++;
        $display("FAIL arst_cnt cycle%0d got %0d want %0d", i, i < cnt_q.size() ? cnt_q[i] : 16'hffff, ec[i]);
      end
    end
  endtask

  task automatic test_random();
    byte_t exp_q[$];
    int ecnt[$];
    int run = 0;
    int k = 0;
    for (int i = 0; i < 60; i++) begin
      word_t x;
      x.d = $urandom;
      x.ds = 2'($urandom_range(3));
      x.s = $urandom_range(3) == 0;
      x.e = (i == 59) || ($urandom_range(3) == 0);
      in_q.push_back(x);
      for (int b = 0; b < (x.ds == 2'd0 ? 1 : x.ds == 2'd1 ? 2 : 4); b++) begin
        logic [31:0] sh;
        logic ls, le;
        sh = x.d >> (8 * b);
        ls = x.s && b == 0;
        le = x.e && b == (x.ds == 2'd0 ? 0 : x.ds == 2'd1 ? 1 : 3);
        run = ls ? 1 : run + 1;
        exp_q.push_back('{sh[7:0], ls, le});
        ecnt.push_back(run);
        if (le) run = 0;
      end
    end
    for (int i = 0; i < 3000; i++) rdy_q.push_back($urandom_range(3) != 0);
    gaps = 1;
    stream(5000);
    gaps = 0;
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (out_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL rand_byte%0d got %h s=%b e=%b want %h s=%b e=%b", i, out_q[i].d, out_q[i].s, out_q[i].e, exp_q[i].d, exp_q[i].s, exp_q[i].e);
      end
    end
    for (int j = 0; j + 1 < hs_q.size() && k < ecnt.size(); j++) begin
      if (hs_q[j]) begin
        checks++;
        if (cnt_q[j + 1] !== 16'(ecnt[k])) begin errors++; $display("FAIL rand_cnt byte%0d got %0d want %0d", k, cnt_q[j + 1], ecnt[k]); end
        k++;
      end
    end
    for (int j = 1; j < vld_q.size(); j++) begin
      if (vld_q[j - 1] && !rdi_q[j - 1]) begin
        checks++;
        if (vld_q[j] !== 1'b1 || dat_q[j] !== dat_q[j - 1]) begin
          errors++;
          $display("FAIL rand_hold cycle%0d got valid=%b data=%h want 1 %h", j, vld_q[j], dat_q[j], dat_q[j - 1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_mixed_size();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/udma_tx_word_serializer.md
Name: udma_tx_word_serializer

Overview:
- Sits directly downstream of the uDMA TX marked FIFO.
- Consumes 32-bit words tagged with start-of-frame/end-of-frame and emits them byte by byte to a byte-oriented peripheral TX engine (UART/SPI/I2S-style serialiser).
- Per-word datasize decides how many bytes of each word are valid.
- sof/eof are remapped from word granularity to byte granularity, and the block keeps a running per-frame byte count.

Parameters:
- DATA_WIDTH, 32, input word width; must be a multiple of 8.
- CNT_WIDTH, 16, width of the frame byte counter.

Ports:
- clk_i  input  1  clock
- rstn_i  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous clear; drops held word and counters
- cfg_datasize_i  input  2  bytes per word: 0=1, 1=2, 2=4, 3=reserved (treated as 4)
- data_i  input  DATA_WIDTH  word from FIFO
- sof_i  input  1  word is first of frame
- eof_i  input  1  word is last of frame
- valid_i  input  1  word valid
- ready_o  output  1  word accepted when valid_i & ready_o
- data_o  output  8  byte to peripheral
- sof_o  output  1  first byte of frame
- eof_o  output  1  last byte of frame
- valid_o  output  1  byte valid
- ready_i  input  1  byte accepted when valid_o & ready_i
- frame_cnt_o  output  CNT_WIDTH  bytes handed off in current frame
- busy_o  output  1  held word not yet fully drained

Behaviour:
- Reset (rstn_i low, async) values:
  - valid_o=0, data_o=0, sof_o=0, eof_o=0, frame_cnt_o=0, busy_o=0.
  - ready_o=1, because the holding register is empty.
- Holding register fields: r_word, r_sof, r_eof, r_nbytes (1/2/4), r_idx (byte index), r_full.
- Capture: on valid_i & ready_o, load data_i, sof_i, eof_i, and nbytes decoded from cfg_datasize_i. Set r_idx=0 and r_full=1. Datasize is sampled per word at capture time.
- States:
  - EMPTY (r_full=0).
  - SHIFT (r_full=1).
- Outputs in SHIFT:
  - valid_o=1.
  - data_o = r_word[8*r_idx +: 8], little-endian (byte 0 first).
  - sof_o = r_sof & (r_idx==0).
  - eof_o = r_eof & (r_idx==r_nbytes-1).
- Byte handshake (valid_o & ready_i):
  - If not the last byte: r_idx increments.
  - If the last byte: the word is drained.
- ready_o = ~r_full | (valid_o & ready_i & last byte). A combinational ready_i->ready_o path is intended, giving back-to-back words with no bubble.
  - Max throughput: 1 byte/cycle.
  - Latency: 1 cycle from word capture to first valid_o.
- Drain with simultaneous capture: the new word loads in the same cycle, and r_full stays 1.
- Drain with no new word: go to EMPTY, valid_o=0 next cycle.
- valid_o must never drop while ready_i is low. data_o, sof_o and eof_o stay stable until accepted.
- A 1-byte word with both sof and eof asserts sof_o and eof_o on the same byte.
- frame_cnt_o, on a byte handshake:
  - If sof_o: load 1.
  - Else: increment, saturating at all-ones.
  - The cycle after a handshake with eof_o, frame_cnt_o returns to 0.
  - If sof_o and eof_o are on the same byte, the count is 1 for one cycle, then 0.
- busy_o = r_full.
- clr_i priority:
  - clr_i overrides all handshakes: r_full=0, r_idx=0, frame_cnt=0.
  - valid_o is 0 the next cycle, and no word is accepted in the clr_i cycle (ready_o is forced to 0 while clr_i is high).
- No frame checking: bytes outside a sof/eof bracket are still passed through, and frame_cnt keeps incrementing without a sof.

Test Plan:
- Single word 0x44332211, datasize=2, sof=eof=1, ready_i=1:
  - Bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - sof_o only with 0x11, eof_o only with 0x44.
  - frame_cnt_o goes 1, 2, 3, 4, then 0.
- Two back-to-back words (0xA1B2C3D4 sof, 0x11223344 eof), datasize=2, valid_i held high:
  - 8 bytes D4 C3 B2 A1 44 33 22 11 with no bubble.
  - ready_o pulses high exactly on the cycles byte A1 and byte 11 are accepted.
- Datasize=0 then datasize=1, words 0x000000AA (sof) and 0x0000CCBB (eof):
  - Bytes AA, BB, CC; sof on AA, eof on CC; upper bytes never emitted.
- Backpressure, ready_i low 3 cycles mid-word on byte 0x22:
  - valid_o stays 1 and data_o stays 0x22 throughout; no byte lost or duplicated; ready_o stays 0.
- clr_i pulsed while byte index 1 of a held word is presented:
  - valid_o=0, busy_o=0, frame_cnt_o=0 next cycle.
  - The next word starts again at its byte 0.
- Async reset asserted mid-word:
  - All outputs take their reset values immediately.
  - After release, a datasize=0 sof+eof word 0x5A yields a single byte with sof_o=eof_o=1.
